// File: rtl/using_the_tanh_if.sv
// Vector handshake bundle for the tanh array wrapper.
// Master drives x; slave returns Output and FinishedTanh.
interface using_the_tanh_if #(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 32
) ();
    logic [N*DATA_WIDTH-1:0] x;
    logic [N*DATA_WIDTH-1:0] Output;
    logic                    FinishedTanh;

    modport master (
        output x,
        input  Output,
        input  FinishedTanh
    );

    modport slave (
        input  x,
        output Output,
        output FinishedTanh
    );
endinterface

// File: rtl/using_the_tanh.sv
// Sequential binary32 tanh over a packed vector, one shared datapath.
// Define TANH_NAN_PROP_EN to map NaN inputs to canonical quiet NaN.
module using_the_tanh #(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 32
) (
    input logic             clk,
    input logic             resetExternal,
    using_the_tanh_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [31:0] C3 = 32'h3EAAAAAB;
    localparam logic [31:0] C5 = 32'h3E088889;
    localparam logic [31:0] C7 = 32'h3D5D0DD1;
    localparam logic [31:0] SB = 32'h80000000;

    typedef enum logic [1:0] {IDLE, POW, SUM, DONE} state_t;
    typedef enum logic [1:0] {K_NUM, K_ZERO, K_SAT, K_NAN} kind_t;

    // Round-to-nearest-even and pack; underflow flushes to signed zero.
    function automatic logic [31:0] pack(
        input logic        s,
        input int          e,
        input logic [22:0] m,
        input logic        g,
        input logic        st
    );
        logic [23:0] r;
        int          ee;
        ee = e;
        r  = {1'b0, m} + {23'b0, g & (st | m[0])};
        if (r[23]) ee = ee + 1;
        if (ee <= 0) return {s, 31'b0};
        if (ee >= 255) return {s, 8'hFF, 23'b0};
        return {s, ee[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] fmul(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic        s;
        logic [47:0] p;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47])
            return pack(s, e + 1, p[46:24], p[23], |p[22:0]);
        return pack(s, e, p[45:23], p[22], |p[21:0]);
    endfunction

    function automatic logic [31:0] fadd(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] bg, sm;
        logic [49:0] mb, ms, mask;
        logic [50:0] r;
        logic        st;
        int          d, lz, e;
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0)
            return {a[31] & b[31], 31'b0};
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] >= b[30:0]) begin
            bg = a;
            sm = b;
        end else begin
            bg = b;
            sm = a;
        end
        d  = int'(bg[30:23]) - int'(sm[30:23]);
        mb = {1'b1, bg[22:0], 26'b0};
        ms = {1'b1, sm[22:0], 26'b0};
        if (d >= 50) begin
            ms = 50'd1;
        end else begin
            mask  = ~({50{1'b1}} << d);
            st    = |(ms & mask);
            ms    = ms >> d;
            ms[0] = ms[0] | st;
        end
        if (a[31] ^ b[31]) r = {1'b0, mb} - {1'b0, ms};
        else               r = {1'b0, mb} + {1'b0, ms};
        if (r == 51'd0) return 32'h0;
        lz = 0;
        for (int i = 0; i < 51; i++)
            if (r[i]) lz = 50 - i;
        r = r << lz;
        e = int'(bg[30:23]) + 1 - lz;
        return pack(bg[31], e, r[49:27], r[26], |r[25:0]);
    endfunction

    state_t              st_q;
    logic [IW-1:0]       idx;
    logic [N*W-1:0]      x_q;
    logic [N*W-1:0]      out_q;
    logic                fin_q;
    logic [31:0]         v_q, p2_q, p3_q, p5_q, p7_q;
    kind_t               kind_q;

    logic [31:0] cur, vf, p2, p3, p5, p7;
    logic [31:0] ta, tb, tc, t, res;
    kind_t       kind;

    assign cur = x_q[W*(N-1-int'(idx)) +: W];

    always_comb begin
        vf   = cur;
        kind = K_NUM;
        if (cur[30:23] == 8'd0) begin
            vf   = {cur[31], 31'b0};
            kind = K_ZERO;
        end else if (cur[30:23] >= 8'd127) begin
            kind = K_SAT;
`ifdef TANH_NAN_PROP_EN
            if (cur[30:23] == 8'hFF && cur[22:0] != 23'd0)
                kind = K_NAN;
`endif
        end
    end

    assign p2 = fmul(vf, vf);
    assign p3 = fmul(p2, vf);
    assign p5 = fmul(p3, p2);
    assign p7 = fmul(p5, p2);

    assign ta = fmul(p3_q, C3);
    assign tb = fmul(p5_q, C5);
    assign tc = fmul(p7_q, C7);
    assign t  = fadd(fadd(fadd(v_q, ta ^ SB), tb), tc ^ SB);

    always_comb begin
        res = t;
        unique case (kind_q)
            K_ZERO: res = {v_q[31], 31'b0};
            K_SAT:  res = {v_q[31], 31'h3F800000};
            K_NAN:  res = 32'h7FC00000;
            K_NUM:  res = t;
        endcase
    end

    always_ff @(posedge clk or negedge resetExternal) begin
        if (!resetExternal) begin
            st_q   <= IDLE;
            idx    <= '0;
            x_q    <= '0;
            out_q  <= '0;
            fin_q  <= 1'b0;
            v_q    <= '0;
            p2_q   <= '0;
            p3_q   <= '0;
            p5_q   <= '0;
            p7_q   <= '0;
            kind_q <= K_ZERO;
        end else begin
            unique case (st_q)
                IDLE: begin
                    x_q  <= bus.x;
                    idx  <= '0;
                    st_q <= POW;
                end
                POW: begin
                    v_q    <= vf;
                    p2_q   <= p2;
                    p3_q   <= p3;
                    p5_q   <= p5;
                    p7_q   <= p7;
                    kind_q <= kind;
                    st_q   <= SUM;
                end
                SUM: begin
                    out_q[W*(N-1-int'(idx)) +: W] <= res;
                    if (idx == IW'(N - 1)) begin
                        st_q <= DONE;
                    end else begin
                        idx  <= idx + 1'b1;
                        st_q <= POW;
                    end
                end
                DONE: fin_q <= 1'b1;
            endcase
        end
    end

    assign bus.Output       = out_q;
    assign bus.FinishedTanh = fin_q;
endmodule

// File: tb/tb_using_the_tanh.sv
// Bench for using_the_tanh: directed vectors, reset abort, hold, random.
// Reference tanh is evaluated in real arithmetic, rounded to binary32.
module tb_using_the_tanh;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    using_the_tanh_if #(.N(2), .DATA_WIDTH(32)) bus ();

    using_the_tanh #(.N(2), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .resetExternal(rst_n),
        .bus          (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic real b2r(input logic [31:0] f);
        real m;
        if (f[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        m = m * (2.0 ** real'(int'(f[30:23]) - 127));
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [52:0] m;
        logic [24:0] k;
        int          e;
        if (r == 0.0) return 32'h0;
        b = $realtobits(r);
        e = int'(b[62:52]) - 1023 + 127;
        m = {1'b1, b[51:0]};
        k = {1'b0, m[52:29]} + 25'(m[28] & ((|m[27:0]) | m[29]));
        if (k[24]) begin
            e = e + 1;
            k = k >> 1;
        end
        if (e <= 0) return {b[63], 31'h0};
        if (e >= 255) return {b[63], 8'hFF, 23'h0};
        return {b[63], e[7:0], k[22:0]};
    endfunction

    function automatic real rf(input real r);
        return b2r(r2f(r));
    endfunction

    function automatic logic [31:0] tanh_ref(input logic [31:0] x);
        real v, p2, p3, p5, p7, a, b, c, t;
`ifdef TANH_NAN_PROP_EN
        if (x[30:23] == 8'hFF && x[22:0] != 0) return 32'h7FC00000;
`endif
        if (x[30:23] >= 8'd127) return x[31] ? 32'hBF800000 : 32'h3F800000;
        if (x[30:23] == 8'd0) return {x[31], 31'h0};
        v  = b2r(x);
        p2 = rf(v * v);
        p3 = rf(p2 * v);
        p5 = rf(p3 * p2);
        p7 = rf(p5 * p2);
        a  = rf(p3 * b2r(32'h3EAAAAAB));
        b  = rf(p5 * b2r(32'h3E088889));
        c  = rf(p7 * b2r(32'h3D5D0DD1));
        t  = rf(rf(rf(v - a) + b) - c);
        return r2f(t);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp, input int tol);
        logic ok;
        int   dd;
        dd = int'(obs[30:0]) - int'(exp[30:0]);
        ok = (obs === exp) ||
             (tol > 0 && obs[31] === exp[31] && dd >= -tol && dd <= tol);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        rst_n = 1'b0;
        bus.x = {a, b};
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus.FinishedTanh !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_fin"}, 32'(bus.FinishedTanh), 32'd1, 0);
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ea,
                           input logic [31:0] eb, input int tol);
        start(a, b);
        wait_done(tag);
        chk({tag, "_w0"}, bus.Output[63:32], ea, tol);
        chk({tag, "_w1"}, bus.Output[31:0], eb, tol);
    endtask

    function automatic logic [31:0] rnd_f();
        logic [31:0] f;
        f = $urandom;
        case ($urandom_range(0, 9))
            0: f[30:23] = 8'(127 + $urandom_range(0, 3));
            1: f[30:0] = '0;
            default: f[30:23] = 8'(110 + $urandom_range(0, 16));
        endcase
        return f;
    endfunction

    initial begin
        logic [63:0] held;
        logic [31:0] a, b;
        bus.x = 64'h0;
        #12;
        chk("reset_out_hi", bus.Output[63:32], 32'h0, 0);
        chk("reset_out_lo", bus.Output[31:0], 32'h0, 0);
        chk("reset_fin", 32'(bus.FinishedTanh), 32'd0, 0);

        run_vec("pos", 32'h3F19999A, 32'h40400000,
                32'h3F096F7B, 32'h3F800000, 1);
        run_vec("neg", 32'hBF19999A, 32'hC0400000,
                32'hBF096F7B, 32'hBF800000, 1);
        run_vec("zero_one", 32'h00000000, 32'h3F800000,
                32'h00000000, 32'h3F800000, 0);
`ifdef TANH_NAN_PROP_EN
        run_vec("nan_den", 32'h7FC00000, 32'h00000001,
                32'h7FC00000, 32'h00000000, 0);
`else
        run_vec("nan_den", 32'h7FC00000, 32'h00000001,
                32'h3F800000, 32'h00000000, 0);
`endif
        run_vec("negzero", 32'h80000000, 32'h80000005,
                32'h80000000, 32'h80000000, 0);

        start(32'h3F19999A, 32'h40400000);
        repeat (2) @(negedge clk);
        chk("abort_e2_w0", bus.Output[63:32], 32'h0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_rst_w0", bus.Output[63:32], 32'h0, 0);
        chk("abort_rst_fin", 32'(bus.FinishedTanh), 32'd0, 0);
        a = 32'hBE800000;
        b = 32'h3F400000;
        bus.x = {a, b};
        @(negedge clk);
        chk("abort_hold_w1", bus.Output[31:0], 32'h0, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_e3_w0", bus.Output[63:32], tanh_ref(a), 1);
        chk("abort_e3_w1", bus.Output[31:0], 32'h0, 0);
        repeat (2) @(negedge clk);
        chk("abort_e5_fin", 32'(bus.FinishedTanh), 32'd0, 0);
        chk("abort_e5_w1", bus.Output[31:0], tanh_ref(b), 1);
        @(negedge clk);
        chk("abort_e6_fin", 32'(bus.FinishedTanh), 32'd1, 0);

        held = bus.Output;
        bus.x = {32'h3E000000, 32'hC0000000};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_out_hi", bus.Output[63:32], held[63:32], 0);
            chk("hold_out_lo", bus.Output[31:0], held[31:0], 0);
            chk("hold_fin", 32'(bus.FinishedTanh), 32'd1, 0);
        end

        for (int i = 0; i < 24; i++) begin
            a = rnd_f();
            b = rnd_f();
            run_vec("rand", a, b, tanh_ref(a), tanh_ref(b), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
